// File: rtl/charlieplex_led_scanner.sv
// Charlieplexed digit scanner: one LED lit at a time, double-buffered frame,
// PWM brightness with per-slot dead time, registered tristate pad controls.
module charlieplex_led_scanner #(
  parameter int unsigned NUM_LINES    = 8,
  parameter int unsigned SEG_PERIOD   = 215,
  parameter int unsigned DEAD_CYCLES  = 2,
  parameter int unsigned BRIGHT_W     = 4,
  parameter int unsigned COMMON_ANODE = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 enable_i,
  input  logic [NUM_LINES*(NUM_LINES-1)-1:0]   frame_data_i,
  input  logic                                 frame_valid_i,
  output logic                                 frame_ready_o,
  input  logic [BRIGHT_W-1:0]                  brightness_i,
  output logic [NUM_LINES-1:0]                 drv_o,
  output logic [NUM_LINES-1:0]                 tris_o,
  output logic [NUM_LINES-1:0]                 digit_o,
  output logic                                 frame_start_o
);

  localparam int unsigned SEGS    = NUM_LINES - 1;
  localparam int unsigned FRAME_W = NUM_LINES * SEGS;
  localparam int unsigned LINE_W  = $clog2(NUM_LINES);
  localparam int unsigned SEG_W   = $clog2(SEGS);
  localparam int unsigned TIMER_W = $clog2(SEG_PERIOD + 2);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SEG_PERIOD);
  localparam logic [TIMER_W-1:0] TIMER_DEAD = TIMER_W'(DEAD_CYCLES);
  localparam logic [SEG_W-1:0]   SEG_LAST   = SEG_W'(SEGS - 1);
  localparam logic [LINE_W-1:0]  DIG_LAST   = LINE_W'(NUM_LINES - 1);
  localparam logic               ANODE_LVL  = 1'(COMMON_ANODE);

  logic                 run_q;
  logic [TIMER_W-1:0]   timer_q, timer_n;
  logic [SEG_W-1:0]     seg_q, seg_n;
  logic [LINE_W-1:0]    dig_q, dig_n;
  logic [BRIGHT_W-1:0]  pwm_q, pwm_n;
  logic [BRIGHT_W-1:0]  bright_q, bright_n;
  logic [FRAME_W-1:0]   active_q, active_n;
  logic [FRAME_W-1:0]   shadow_q, shadow_n;
  logic                 ready_n;
  logic                 wrap;
  logic [SEGS-1:0]      row_bits;
  logic [LINE_W-1:0]    line;
  logic                 pwm_on;
  logic                 lit;
  logic [NUM_LINES-1:0] drv_n, tris_n, digit_n;
  logic                 frame_start_n;

  // Next scan position, buffers and handshake; the outputs are then derived
  // from the next position so the registered outputs match the state they sit beside.
  always_comb begin
    timer_n       = timer_q;
    seg_n         = seg_q;
    dig_n         = dig_q;
    pwm_n         = pwm_q + BRIGHT_W'(1);
    bright_n      = bright_q;
    active_n      = active_q;
    shadow_n      = shadow_q;
    ready_n       = frame_ready_o;
    row_bits      = '0;
    line          = '0;
    pwm_on        = 1'b0;
    lit           = 1'b0;
    drv_n         = '0;
    tris_n        = '1;
    digit_n       = '0;
    frame_start_n = 1'b0;

    // The first edge after reset release acts as a frame boundary into slot (0,0).
    wrap = !run_q || (timer_q == TIMER_LAST && seg_q == SEG_LAST && dig_q == DIG_LAST);

    if (!run_q) begin
      timer_n = '0;
      seg_n   = '0;
      dig_n   = '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_n = '0;
      if (seg_q == SEG_LAST) begin
        seg_n = '0;
        dig_n = (dig_q == DIG_LAST) ? '0 : dig_q + LINE_W'(1);
      end else begin
        seg_n = seg_q + SEG_W'(1);
      end
    end else begin
      timer_n = timer_q + TIMER_W'(1);
    end

    if (timer_n == TIMER_DEAD) pwm_n = '0;

    if (wrap) begin
      bright_n = brightness_i;
      if (!frame_ready_o) begin
        active_n = shadow_q;
        ready_n  = 1'b1;
      end
    end

    if (frame_valid_i && frame_ready_o) begin
      shadow_n = frame_data_i;
      ready_n  = 1'b0;
    end

    for (int d = 0; d < NUM_LINES; d++) begin
      if (dig_n == LINE_W'(d)) row_bits = active_n[d*SEGS +: SEGS];
    end

    // Segment lines skip over the digit's own common line.
    line   = (LINE_W'(seg_n) < dig_n) ? LINE_W'(seg_n) : LINE_W'(seg_n) + LINE_W'(1);
    pwm_on = (bright_n == '1) || (pwm_n < bright_n);
    lit    = enable_i && (timer_n >= TIMER_DEAD) && row_bits[seg_n] && pwm_on;

    if (lit) begin
      tris_n[dig_n] = 1'b0;
      tris_n[line]  = 1'b0;
      drv_n[dig_n]  = ANODE_LVL;
      drv_n[line]   = ~ANODE_LVL;
    end

    digit_n       = NUM_LINES'(1) << dig_n;
    frame_start_n = (timer_n == '0) && (seg_n == '0) && (dig_n == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      run_q         <= 1'b0;
      timer_q       <= '0;
      seg_q         <= '0;
      dig_q         <= '0;
      pwm_q         <= '0;
      bright_q      <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      frame_ready_o <= 1'b1;
      drv_o         <= '0;
      tris_o        <= '1;
      digit_o       <= NUM_LINES'(1);
      frame_start_o <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      timer_q       <= timer_n;
      seg_q         <= seg_n;
      dig_q         <= dig_n;
      pwm_q         <= pwm_n;
      bright_q      <= bright_n;
      active_q      <= active_n;
      shadow_q      <= shadow_n;
      frame_ready_o <= ready_n;
      drv_o         <= drv_n;
      tris_o        <= tris_n;
      digit_o       <= digit_n;
      frame_start_o <= frame_start_n;
    end
  end

endmodule
